// File: rtl/anita4_event_ring_buffer.sv
// Multi-buffer event store between digitizer readout (16-bit writes) and the
// host read path (32-bit reads). Buffers are allocated and retired in ring order.
module anita4_event_ring_buffer #(
  parameter int NBUF  = 4,
  parameter int RD_AW = 6
) (
  input  logic                     clk33_i,
  input  logic                     rst_i,
  input  logic [RD_AW:0]           event_wr_addr_i,
  input  logic [15:0]              event_wr_dat_i,
  input  logic                     event_wr_i,
  input  logic                     event_done_i,
  output logic                     wr_ready_o,
  output logic [$clog2(NBUF)-1:0]  wr_buffer_o,
  input  logic [RD_AW-1:0]         event_rd_addr_i,
  output logic [31:0]              event_rd_dat_o,
  output logic [$clog2(NBUF)-1:0]  read_buffer_o,
  output logic                     evt_avail_o,
  input  logic                     clear_evt_i,
  input  logic                     status_clr_i,
  output logic [31:0]              status_o
);

  localparam int PW    = $clog2(NBUF);
  localparam int CW    = PW + 1;
  localparam int DEPTH = NBUF << RD_AW;

  // 16-bit address space split into even/odd banks so a 32-bit word reads in one cycle
  logic [15:0] mem_lo [DEPTH];
  logic [15:0] mem_hi [DEPTH];

  logic [PW-1:0]   wptr, rptr;
  logic [CW-1:0]   count;
  logic [NBUF-1:0] active, active_nxt;
  logic [7:0]      drop_cnt;
  logic            ovf_sticky, unf_sticky;
  logic            full, empty, done_ok, clr_ok;

  assign full    = (count == CW'(NBUF));
  assign empty   = (count == '0);
  assign done_ok = event_done_i && !full;
  assign clr_ok  = clear_evt_i && !empty;

  assign wr_ready_o  = !full;
  assign evt_avail_o = !empty;
  assign wr_buffer_o = wptr;

  assign status_o = {drop_cnt, ovf_sticky, unf_sticky, evt_avail_o, 5'b0,
                     8'(active), 4'(count), 1'b0, 3'(rptr)};

  // wptr == rptr only when empty or full, so both updates never hit the same bit
  always_comb begin
    active_nxt = active;
    if (done_ok) active_nxt[wptr] = 1'b1;
    if (clr_ok)  active_nxt[rptr] = 1'b0;
  end

  always_ff @(posedge clk33_i) begin
    if (event_wr_i && !full) begin
      if (event_wr_addr_i[0]) mem_hi[{wptr, event_wr_addr_i[RD_AW:1]}] <= event_wr_dat_i;
      else                    mem_lo[{wptr, event_wr_addr_i[RD_AW:1]}] <= event_wr_dat_i;
    end
  end

  always_ff @(posedge clk33_i) begin
    if (rst_i) event_rd_dat_o <= '0;
    else       event_rd_dat_o <= {mem_hi[{rptr, event_rd_addr_i}], mem_lo[{rptr, event_rd_addr_i}]};
  end

  always_ff @(posedge clk33_i) begin
    if (rst_i) begin
      wptr          <= '0;
      rptr          <= '0;
      count         <= '0;
      active        <= '0;
      drop_cnt      <= '0;
      ovf_sticky    <= 1'b0;
      unf_sticky    <= 1'b0;
      read_buffer_o <= '0;
    end else begin
      read_buffer_o <= rptr;
      active        <= active_nxt;
      if (done_ok) wptr <= wptr + 1'b1;
      if (clr_ok)  rptr <= rptr + 1'b1;
      if (done_ok && !clr_ok)      count <= count + 1'b1;
      else if (clr_ok && !done_ok) count <= count - 1'b1;
      if (status_clr_i) begin
        drop_cnt   <= '0;
        ovf_sticky <= 1'b0;
        unf_sticky <= 1'b0;
      end else begin
        if (event_wr_i && full && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        if (event_done_i && full)  ovf_sticky <= 1'b1;
        if (clear_evt_i && empty)  unf_sticky <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_anita4_event_ring_buffer.sv
// Bench for anita4_event_ring_buffer: queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_anita4_event_ring_buffer;

  localparam int NBUF  = 4;
  localparam int RD_AW = 6;
  localparam int PW    = $clog2(NBUF);
  localparam int WW    = 2 ** (RD_AW + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1;
  logic [RD_AW:0]   wr_addr = '0;
  logic [15:0]      wr_dat = '0;
  logic             wr = 1'b0, done = 1'b0, clr = 1'b0, sclr = 1'b0;
  logic [RD_AW-1:0] rd_addr = '0;
  logic             wr_ready, avail;
  logic [PW-1:0]    wr_buf, rd_buf;
  logic [31:0]      rd_dat, status;

  anita4_event_ring_buffer #(.NBUF(NBUF), .RD_AW(RD_AW)) dut (
    .clk33_i(clk), .rst_i(rst),
    .event_wr_addr_i(wr_addr), .event_wr_dat_i(wr_dat), .event_wr_i(wr),
    .event_done_i(done), .wr_ready_o(wr_ready), .wr_buffer_o(wr_buf),
    .event_rd_addr_i(rd_addr), .event_rd_dat_o(rd_dat), .read_buffer_o(rd_buf),
    .evt_avail_o(avail), .clear_evt_i(clr), .status_clr_i(sclr), .status_o(status)
  );

  int errors = 0, checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending buffers as a queue, write pointer derived from it
  int         q[$];
  int         m_rptr = 0, m_drop = 0, m_rb = 0;
  bit         m_ovf = 1'b0, m_unf = 1'b0, m_rd_ok = 1'b0, chk_en = 1'b0;
  logic [31:0] m_rd = '0;
  bit [15:0]  mm [NBUF][WW];
  bit         mv [NBUF][WW];

  function automatic int m_wptr();
    return (m_rptr + q.size()) % NBUF;
  endfunction

  function automatic logic [31:0] m_status();
    logic [7:0] act = '0;
    foreach (q[i]) act[q[i]] = 1'b1;
    return {8'(m_drop), m_ovf, m_unf, q.size() != 0, 5'd0, act, 4'(q.size()), 1'b0, 3'(m_rptr)};
  endfunction

  always @(posedge clk) begin
    int n, w, k;
    bit d_ok, c_ok;
    if (rst) begin
      q.delete();
      m_rptr = 0; m_drop = 0; m_ovf = 0; m_unf = 0; m_rb = 0;
      m_rd = '0; m_rd_ok = 1'b1; chk_en = 1'b1;
      foreach (mv[b, a]) mv[b][a] = 1'b0;
    end else begin
      n = q.size();
      w = m_wptr();
      k = int'(rd_addr);
      m_rd_ok = mv[m_rptr][2*k] && mv[m_rptr][2*k+1];
      m_rd    = {mm[m_rptr][2*k+1], mm[m_rptr][2*k]};
      m_rb    = m_rptr;
      if (wr) begin
        if (n != NBUF) begin
          mm[w][wr_addr] = wr_dat;
          mv[w][wr_addr] = 1'b1;
        end else if (m_drop < 255) m_drop++;
      end
      d_ok = done && n != NBUF;
      c_ok = clr && n != 0;
      if (done && !d_ok) m_ovf = 1'b1;
      if (clr && !c_ok)  m_unf = 1'b1;
      if (sclr) begin m_drop = 0; m_ovf = 0; m_unf = 0; end
      if (c_ok) begin void'(q.pop_front()); m_rptr = (m_rptr + 1) % NBUF; end
      if (d_ok) q.push_back(w);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("wr_ready", 32'(wr_ready), 32'(q.size() != NBUF));
      check("evt_avail", 32'(avail), 32'(q.size() != 0));
      check("wr_buffer", 32'(wr_buf), 32'(m_wptr()));
      check("read_buffer", 32'(rd_buf), 32'(m_rb));
      check("status", status, m_status());
      if (m_rd_ok) check("rd_dat", rd_dat, m_rd);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic write(input int a, input int d);
    wr = 1'b1; wr_addr = (RD_AW+1)'(a); wr_dat = 16'(d);
    tick();
    wr = 1'b0;
  endtask

  task automatic pulse(input bit d, input bit c);
    done = d; clr = c; tick(); done = 1'b0; clr = 1'b0;
  endtask

  initial begin
    tick(); tick();
    rst = 1'b0;
    check("rst_ready", 32'(wr_ready), 32'd1);
    check("rst_avail", 32'(avail), 32'd0);

    // Single event, word 5 = 16-bit addresses 11:10
    for (int i = 0; i < WW; i++) write(i, 'h1000 + i);
    pulse(1, 0);
    rd_addr = 5;
    tick();
    check("t1_rd", rd_dat, 32'h100B100A);
    check("t1_model_rd", m_rd, 32'h100B100A);
    check("t1_avail", 32'(avail), 32'd1);
    check("t1_count", 32'(status[7:4]), 32'd1);
    check("t1_active", 32'(status[15:8]), 32'h01);

    // Fill the ring, then overflow and dropped writes
    for (int b = 1; b < NBUF; b++) begin
      for (int i = 0; i < 4; i++) write(i, 'h2000 + b * 256 + i);
      pulse(1, 0);
    end
    check("t2_ready", 32'(wr_ready), 32'd0);
    check("t2_count", 32'(status[7:4]), 32'd4);
    pulse(1, 0);
    check("t2_ovf", 32'(status[23]), 32'd1);
    check("t2_count_stay", 32'(status[7:4]), 32'd4);
    check("t2_wptr_stay", 32'(wr_buf), 32'd0);
    for (int i = 0; i < 3; i++) write(10, 'hDEAD);
    check("t2_drop", 32'(status[31:24]), 32'd3);
    tick();
    check("t2_readback", rd_dat, 32'h100B100A);

    // Simultaneous done/clear when full, then when empty
    pulse(1, 1);
    check("t3f_count", 32'(status[7:4]), 32'd3);
    check("t3f_rptr", 32'(status[2:0]), 32'd1);
    check("t3f_wptr", 32'(wr_buf), 32'd0);
    check("t3f_ovf", 32'(status[23]), 32'd1);
    do_reset();
    pulse(1, 1);
    check("t3e_count", 32'(status[7:4]), 32'd1);
    check("t3e_unf", 32'(status[22]), 32'd1);
    check("t3e_rptr", 32'(status[2:0]), 32'd0);
    check("t3e_wptr", 32'(wr_buf), 32'd1);

    // Wrap-around: nine fill/read/clear rounds
    do_reset();
    for (int p = 1; p <= 9; p++) begin
      write(2, 'hA000 + p);
      write(3, 'hB000 + p);
      pulse(1, 0);
      rd_addr = 1;
      tick();
      check("t4_rd", rd_dat, 32'((('hB000 + p) << 16) | ('hA000 + p)));
      pulse(0, 1);
    end
    check("t4_wptr", 32'(wr_buf), 32'd1);
    check("t4_rptr", 32'(status[2:0]), 32'd1);
    tick();
    check("t4_read_buffer", 32'(rd_buf), 32'd1);

    // Drop counter saturation, then clear with a competing drop
    do_reset();
    for (int b = 0; b < NBUF; b++) pulse(1, 0);
    for (int i = 0; i < 300; i++) write(0, i);
    check("t5_sat", 32'(status[31:24]), 32'd255);
    sclr = 1'b1; wr = 1'b1;
    tick();
    sclr = 1'b0; wr = 1'b0;
    check("t5_clr", 32'(status[31:22]), 32'd0);

    // Reset in the middle of an event
    do_reset();
    for (int b = 0; b < 3; b++) pulse(1, 0);
    pulse(0, 1);
    write(0, 1);
    write(1, 2);
    check("t6_pre_rb", 32'(rd_buf), 32'd1);
    check("t6_pre_count", 32'(status[7:4]), 32'd2);
    wr = 1'b1; rst = 1'b1;
    tick();
    wr = 1'b0; rst = 1'b0;
    check("t6_count", 32'(status[7:4]), 32'd0);
    check("t6_active", 32'(status[15:8]), 32'd0);
    check("t6_ready", 32'(wr_ready), 32'd1);
    check("t6_avail", 32'(avail), 32'd0);
    check("t6_rb", 32'(rd_buf), 32'd0);
    check("t6_wptr", 32'(wr_buf), 32'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
